// File: rtl/pacman_motion_ctrl.sv
// rtl/pacman_motion_ctrl.sv - pad-driven grid motion controller with one pending turn and maze ROM probe
// Optional TUNNEL_WRAP_EN: out-of-range neighbours wrap to the opposite maze edge instead of acting as walls.
module pacman_motion_ctrl #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 32,
  parameter int XW       = 5,
  parameter int YW       = 5,
  parameter int MOVE_DIV = 4,
  parameter int START_X  = 13,
  parameter int START_Y  = 23
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  output logic [XW-1:0] probe_x,
  output logic [YW-1:0] probe_y,
  input  logic          wall_hit,
  output logic [XW-1:0] curr_x,
  output logic [YW-1:0] curr_y,
  output logic [1:0]    dir,
  output logic          moving,
  output logic          step_pulse
);

  localparam int CW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(MOVE_DIV - 1);
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  typedef enum logic [1:0] {S_WAIT, S_PEND, S_CUR, S_MOVE} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic          pend_valid, pend_ok, cur_ok;
  logic [1:0]    pend_dir, snap_dir, req_dir;
  logic          req_any;
  logic [XW-1:0] pend_tx, pn_x, cn_x;
  logic [YW-1:0] pend_ty, pn_y, cn_y;
  logic          pn_in, cn_in;

  // Returns {in_range, x, y}; an unwrapped out-of-range move yields the current cell.
  function automatic logic [XW+YW:0] nbr(input logic [XW-1:0] x, input logic [YW-1:0] y,
                                         input logic [1:0] d);
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          inr;
    nx  = x;
    ny  = y;
    inr = 1'b1;
    case (d)
      D_UP: begin
        if (y == '0) begin
`ifdef TUNNEL_WRAP_EN
          ny = YW'(GRID_H - 1);
`else
          inr = 1'b0;
`endif
        end else ny = y - 1'b1;
      end
      D_DOWN: begin
        if (y == YW'(GRID_H - 1)) begin
`ifdef TUNNEL_WRAP_EN
          ny = '0;
`else
          inr = 1'b0;
`endif
        end else ny = y + 1'b1;
      end
      D_LEFT: begin
        if (x == '0) begin
`ifdef TUNNEL_WRAP_EN
          nx = XW'(GRID_W - 1);
`else
          inr = 1'b0;
`endif
        end else nx = x - 1'b1;
      end
      default: begin
        if (x == XW'(GRID_W - 1)) begin
`ifdef TUNNEL_WRAP_EN
          nx = '0;
`else
          inr = 1'b0;
`endif
        end else nx = x + 1'b1;
      end
    endcase
    return {inr, nx, ny};
  endfunction

  assign {pn_in, pn_x, pn_y} = nbr(curr_x, curr_y, pend_dir);
  assign {cn_in, cn_x, cn_y} = nbr(curr_x, curr_y, dir);
  assign tick    = enable && (tick_cnt == TICK_LAST);
  assign req_any = up | down | left | right;

  always_comb begin
    req_dir = D_RIGHT;
    if (up)        req_dir = D_UP;
    else if (down) req_dir = D_DOWN;
    else if (left) req_dir = D_LEFT;
  end

  always_comb begin
    probe_x = curr_x;
    probe_y = curr_y;
    case (state)
      S_PEND: if (pend_valid) begin
        probe_x = pn_x;
        probe_y = pn_y;
      end
      S_CUR: begin
        probe_x = cn_x;
        probe_y = cn_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_WAIT;
      tick_cnt   <= '0;
      curr_x     <= XW'(START_X);
      curr_y     <= YW'(START_Y);
      dir        <= D_LEFT;
      moving     <= 1'b0;
      step_pulse <= 1'b0;
      pend_valid <= 1'b0;
      pend_dir   <= D_LEFT;
      snap_dir   <= D_LEFT;
      pend_tx    <= '0;
      pend_ty    <= '0;
      pend_ok    <= 1'b0;
      cur_ok     <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (enable) tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
      case (state)
        S_WAIT: if (tick) state <= S_PEND;
        S_PEND: begin
          if (!enable) state <= S_WAIT;
          else begin
            // Snapshot the target so a request arriving mid-probe cannot retarget this move.
            pend_ok  <= pend_valid && pn_in && !wall_hit;
            snap_dir <= pend_dir;
            pend_tx  <= pn_x;
            pend_ty  <= pn_y;
            state    <= S_CUR;
          end
        end
        S_CUR: begin
          if (!enable) state <= S_WAIT;
          else begin
            cur_ok <= cn_in && !wall_hit;
            state  <= S_MOVE;
          end
        end
        default: begin
          state <= S_WAIT;
          if (enable) begin
            if (pend_ok) begin
              dir        <= snap_dir;
              curr_x     <= pend_tx;
              curr_y     <= pend_ty;
              moving     <= 1'b1;
              step_pulse <= 1'b1;
              if (pend_dir == snap_dir) pend_valid <= 1'b0;
            end else if (cur_ok) begin
              curr_x     <= cn_x;
              curr_y     <= cn_y;
              moving     <= 1'b1;
              step_pulse <= 1'b1;
            end else begin
              moving <= 1'b0;
            end
          end
        end
      endcase
      if (req_any) begin
        pend_valid <= 1'b1;
        pend_dir   <= req_dir;
      end
    end
  end

endmodule
